// File: rtl/matrix_addsub_seq.sv
// Sequential matrix add/subtract engine: latches two square matrices on start,
// processes LANES elements per clock with wrap or saturate arithmetic, then pulses done.
module matrix_addsub_seq #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int LANES   = 5,
    parameter int SIZE_W  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                op_sub,
    input  logic                                saturate,
    input  logic [SIZE_W-1:0]                   matrix_size,
    input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]   matrix_A,
    input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]   matrix_B,
    output logic                                busy,
    output logic                                done,
    output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0]   result_out,
    output logic                                overflow
);

    localparam int NELEM = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(NELEM + LANES + 1);
    localparam int SEL_W = (NELEM > 1) ? $clog2(NELEM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ELEM_W-1:0] SAT_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
    localparam logic [ELEM_W-1:0] SAT_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

    logic [1:0]        state;
    logic [IDX_W-1:0]  index;
    logic [IDX_W-1:0]  count_n;
    logic [IDX_W-1:0]  dim_raw;
    logic [IDX_W-1:0]  dim;
    logic [IDX_W-1:0]  next_index;
    logic              last_beat;
    logic              op_sub_q;
    logic              saturate_q;
    logic              accept;

    logic [ELEM_W-1:0] a_mem [NELEM];
    logic [ELEM_W-1:0] b_mem [NELEM];
    logic [ELEM_W-1:0] r_mem [NELEM];

    logic [IDX_W-1:0]  lane_elem [LANES];
    logic [SEL_W-1:0]  lane_sel  [LANES];
    logic [ELEM_W-1:0] lane_a    [LANES];
    logic [ELEM_W-1:0] lane_b    [LANES];
    logic [ELEM_W:0]   lane_sum  [LANES];
    logic [ELEM_W-1:0] lane_res  [LANES];
    logic [LANES-1:0]  lane_act;
    logic [LANES-1:0]  lane_raw_ovf;
    logic [LANES-1:0]  lane_ovf;

    assign accept = (state == S_IDLE) && start;

    // Matrix dimension is size+2, never beyond what the storage holds.
    always_comb begin
        dim_raw = IDX_W'(matrix_size) + IDX_W'(2);
        dim     = (dim_raw > IDX_W'(MAX_DIM)) ? IDX_W'(MAX_DIM) : dim_raw;
    end

    assign next_index = index + IDX_W'(LANES);
    assign last_beat  = (next_index >= count_n);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_elem[l] = index + IDX_W'(l);
            lane_act[l]  = (state == S_RUN) && (lane_elem[l] < count_n);
            // Inactive lanes read element 0 so the array index always stays in range.
            lane_sel[l]  = lane_act[l] ? SEL_W'(lane_elem[l]) : '0;
            lane_a[l]    = a_mem[lane_sel[l]];
            lane_b[l]    = b_mem[lane_sel[l]];
            if (op_sub_q) begin
                lane_sum[l]     = {lane_a[l][ELEM_W-1], lane_a[l]} - {lane_b[l][ELEM_W-1], lane_b[l]};
                lane_raw_ovf[l] = (lane_a[l][ELEM_W-1] != lane_b[l][ELEM_W-1]) &&
                                  (lane_sum[l][ELEM_W-1] != lane_a[l][ELEM_W-1]);
            end else begin
                lane_sum[l]     = {lane_a[l][ELEM_W-1], lane_a[l]} + {lane_b[l][ELEM_W-1], lane_b[l]};
                lane_raw_ovf[l] = (lane_a[l][ELEM_W-1] == lane_b[l][ELEM_W-1]) &&
                                  (lane_sum[l][ELEM_W-1] != lane_a[l][ELEM_W-1]);
            end
            lane_ovf[l] = lane_act[l] && lane_raw_ovf[l];
            if (saturate_q && lane_raw_ovf[l])
                lane_res[l] = lane_a[l][ELEM_W-1] ? SAT_MIN : SAT_MAX;
            else
                lane_res[l] = lane_sum[l][ELEM_W-1:0];
        end
    end

    // NOTE: operand copies carry no reset; they are always rewritten on the accepted start before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int e = 0; e < NELEM; e++) begin
                a_mem[e] <= matrix_A[e*ELEM_W +: ELEM_W];
                b_mem[e] <= matrix_B[e*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            index      <= '0;
            count_n    <= '0;
            op_sub_q   <= 1'b0;
            saturate_q <= 1'b0;
            overflow   <= 1'b0;
            for (int e = 0; e < NELEM; e++) r_mem[e] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        index      <= '0;
                        count_n    <= IDX_W'(dim * dim);
                        op_sub_q   <= op_sub;
                        saturate_q <= saturate;
                        overflow   <= 1'b0;
                        for (int e = 0; e < NELEM; e++) r_mem[e] <= '0;
                    end
                end
                S_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_act[l]) r_mem[lane_sel[l]] <= lane_res[l];
                    end
                    overflow <= overflow | (|lane_ovf);
                    index    <= next_index;
                    if (last_beat) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    for (genvar g = 0; g < NELEM; g++) begin : g_result
        assign result_out[g*ELEM_W +: ELEM_W] = r_mem[g];
    end

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Randomised bench for matrix_addsub_seq, checked against an integer-arithmetic model
// of element-wise add/subtract with wrap or saturation.
module tb_matrix_addsub_seq;

    localparam int EW = 8;
    localparam int MD = 5;
    localparam int NE = MD * MD;
    localparam int LN = 5;
    localparam int SW = 2;

    typedef logic [EW*NE-1:0] flat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          op_sub = 1'b0;
    logic          saturate = 1'b0;
    logic [SW-1:0] matrix_size = '0;
    flat_t         matrix_A = '0;
    flat_t         matrix_B = '0;
    logic          busy;
    logic          done;
    flat_t         result_out;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_addsub_seq #(.ELEM_W(EW), .MAX_DIM(MD), .LANES(LN), .SIZE_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_sub     (op_sub),
        .saturate   (saturate),
        .matrix_size(matrix_size),
        .matrix_A   (matrix_A),
        .matrix_B   (matrix_B),
        .busy       (busy),
        .done       (done),
        .result_out (result_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input flat_t got, input flat_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic flat_t fill(input int v);
        flat_t f;
        for (int i = 0; i < NE; i++) f[i*EW +: EW] = EW'(v);
        return f;
    endfunction

    function automatic flat_t rand_flat();
        flat_t f;
        for (int i = 0; i < NE; i++) f[i*EW +: EW] = EW'($urandom);
        return f;
    endfunction

    // Reference: signed integer add/sub per active element, clamped or wrapped to 8 bits.
    function automatic void model(input logic [SW-1:0] size, input bit sub, input bit sat,
                                  input flat_t a, input flat_t b,
                                  output flat_t r, output bit ovf, output int beats);
        int dim, n, x, y, s;
        dim = int'(size) + 2;
        if (dim > MD) dim = MD;
        n     = dim * dim;
        beats = (n + LN - 1) / LN;
        r     = '0;
        ovf   = 1'b0;
        for (int e = 0; e < n; e++) begin
            x = $signed(a[e*EW +: EW]);
            y = $signed(b[e*EW +: EW]);
            s = sub ? x - y : x + y;
            if (s > 127 || s < -128) begin
                ovf = 1'b1;
                if (sat) s = (s > 127) ? 127 : -128;
            end
            r[e*EW +: EW] = EW'(s);
        end
    endfunction

    task automatic do_op(input logic [SW-1:0] size, input bit sub, input bit sat,
                         input flat_t a, input flat_t b, input bit disturb);
        flat_t exp_r;
        bit    exp_ovf;
        int    exp_beats;
        int    cycles;
        model(size, sub, sat, a, b, exp_r, exp_ovf, exp_beats);
        @(negedge clk);
        matrix_size = size;
        op_sub      = sub;
        saturate    = sat;
        matrix_A    = a;
        matrix_B    = b;
        start       = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (busy && cycles < 64) begin
            if (disturb) begin
                start    = ~start;
                matrix_A = rand_flat();
                op_sub   = ~op_sub;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("busy_cycles", flat_t'(cycles), flat_t'(exp_beats));
        check("done_pulse", flat_t'(done), flat_t'(1));
        check("result", result_out, exp_r);
        check("overflow", flat_t'(overflow), flat_t'(exp_ovf));
        @(negedge clk);
        check("done_clear", flat_t'({busy, done}), flat_t'(0));
        check("result_held", result_out, exp_r);
        check("overflow_held", flat_t'(overflow), flat_t'(exp_ovf));
    endtask

    initial begin
        flat_t a, b, exp_r;
        bit    exp_ovf;
        int    exp_beats;
        int    done_seen;

        #2;
        check("reset_busy_done", flat_t'({busy, done}), flat_t'(0));
        check("reset_result", result_out, '0);
        check("reset_overflow", flat_t'(overflow), flat_t'(0));
        @(negedge clk);
        rst = 1'b0;

        // 2x2 add with wrap, then saturate.
        a = fill(1); b = fill(1);
        a[7:0] = 8'd100; b[7:0] = 8'd50;
        do_op(2'd0, 1'b0, 1'b0, a, b, 1'b0);
        check("t1_elem0", flat_t'(result_out[7:0]), flat_t'(8'h96));
        check("t1_elem3", flat_t'(result_out[31:24]), flat_t'(8'd2));
        do_op(2'd0, 1'b0, 1'b1, a, b, 1'b0);
        check("t2_elem0", flat_t'(result_out[7:0]), flat_t'(8'h7F));

        // 2x2 subtract, saturate at the negative limit.
        a = fill(0); b = fill(0);
        a[7:0] = 8'h80; b[7:0] = 8'd1;
        a[15:8] = 8'd5; b[15:8] = 8'hFD;
        do_op(2'd0, 1'b1, 1'b1, a, b, 1'b0);
        check("t3_elem0", flat_t'(result_out[7:0]), flat_t'(8'h80));
        check("t3_elem1", flat_t'(result_out[15:8]), flat_t'(8'd8));

        // 3x3 add: elements past 8 stay zero.
        do_op(2'd1, 1'b0, 1'b0, fill(3), fill(4), 1'b0);
        check("t4_elem8", flat_t'(result_out[71:64]), flat_t'(8'd7));
        check("t4_elem9", flat_t'(result_out[79:72]), flat_t'(0));

        // 5x5 add with start and operand toggling during RUN.
        do_op(2'd3, 1'b0, 1'b0, rand_flat(), rand_flat(), 1'b1);

        // Reset in the middle of a 5x5 operation.
        a = rand_flat(); b = rand_flat();
        model(2'd3, 1'b0, 1'b0, a, b, exp_r, exp_ovf, exp_beats);
        @(negedge clk);
        matrix_size = 2'd3; op_sub = 1'b0; saturate = 1'b0;
        matrix_A = a; matrix_B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("partial_after_two_beats", result_out, exp_r & {{(NE-10)*EW{1'b0}}, {10*EW{1'b1}}});
        #2 rst = 1'b1;
        #1;
        check("midreset_result", result_out, '0);
        check("midreset_flags", flat_t'({busy, done, overflow}), flat_t'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("no_done_after_reset", flat_t'(done_seen), flat_t'(0));
        a = fill(10); b = fill(20);
        do_op(2'd0, 1'b1, 1'b0, a, b, 1'b0);

        // Random operations across sizes, modes and operand values.
        for (int t = 0; t < 24; t++) begin
            do_op(SW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  rand_flat(), rand_flat(), 1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
